instr_fetch: RTL and testbench

Instruction fetch stage: initiator side of the combinational instruction-memory read port. Owns the program counter, drives the word address to `inst_mem`, captures the returned instruction into a one-entry output register, and hands it to decode over a valid/ready handshake. Supports redirect (branch/jump) with flush, backpressure stall, and a halt instruction that stops fetching.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [0:0] {F_RUN, F_HALTED} fetch_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, imem read initiator and one-entry output register to decode
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_INC        = ADDRESS_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0]    HALT_INSTR    = DATA_WIDTH'(HALT_INSTR_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_pc,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     halted,
  output logic [31:0]              fetch_count
);

  fetch_state_t             state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     load;
  logic                     xfer;

  // Redirect outranks everything: it voids both the load and the handshake.
  assign load    = (state == F_RUN) && (!out_valid || out_ready) && !redirect_valid;
  assign xfer    = out_valid && out_ready && !redirect_valid;
  assign imem_pc = pc;
  assign halted  = (state == F_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (load) begin
      pc <= pc + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_instr <= imem_instr;
      out_pc    <= pc;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // The halt word itself is still captured and delivered; only later loads stop.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = F_RUN;
    end else if (load && (imem_instr == HALT_INSTR)) begin
      state_nxt = F_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (xfer) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] w_imem_pc;
  logic [31:0] w_imem_instr;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_halted;
  logic [31:0] w_fetch_count;

  logic [31:0] mem [0:255];
  exp_t        sb[$];
  int          n_assert;
  int          n_fail;
  int          exp_count;

  assign imem_instr   = mem[imem_pc[7:0]];
  assign w_imem_instr = mem[w_imem_pc[7:0]];

  instr_fetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (w_imem_pc),
    .imem_instr     (w_imem_instr),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (w_out_valid),
    .out_ready      (1'b1),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .halted         (w_halted),
    .fetch_count    (w_fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:0]];
    sb.push_back(e);
  endtask

  // Drive one cycle; when a handshake is expected, pop and compare before the edge.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input bit exp_xfer);
    exp_t e;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (exp_xfer) begin
      chk("xfer_valid", {31'd0, out_valid}, 32'd1);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", out_pc, e.pc);
        chk("xfer_instr", out_instr, e.instr);
      end
      exp_count++;
    end
    @(posedge clk);
    #1;
    chk("fetch_count", fetch_count, exp_count);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    exp_count      = 0;
    for (int i = 0; i < 256; i++) mem[i] = i + 100;
    mem[5]         = 32'h0000_0073;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);
    chk("rst_wrap_imem_pc", w_imem_pc, 32'hFFFF_FFFF);
    rst = 1'b0;

    // Streaming: out_pc 0..3 in cycles 1..4.
    push(0); push(1); push(2); push(3);
    cyc(1, 0, 0, 0);
    chk("c1_out_pc", out_pc, 32'd0);
    chk("wrap_first_pc", w_out_pc, 32'hFFFF_FFFF);
    chk("wrap_first_instr", w_out_instr, 32'd355);
    cyc(1, 0, 0, 1);
    chk("wrap_second_pc", w_out_pc, 32'd0);
    chk("wrap_second_instr", w_out_instr, 32'd100);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("after4_count", fetch_count, 32'd4);

    // Stall holding out_pc=4.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, 32'd4);
      chk("stall_instr", out_instr, 32'd104);
      chk("stall_imem_pc", imem_pc, 32'd5);
    end

    // Release: 4 then halt word at 5 is delivered, then fetching stops.
    push(4); push(5);
    cyc(1, 0, 0, 1);
    chk("halt_loaded_pc", out_pc, 32'd5);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      chk("halted_no_valid", {31'd0, out_valid}, 32'd0);
      chk("halted_imem_pc", imem_pc, 32'd6);
      chk("halted_stays", {31'd0, halted}, 32'd1);
    end

    // Redirect out of halt to 0.
    cyc(1, 1, 32'h0, 0);
    chk("unhalt_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("unhalt_imem_pc", imem_pc, 32'd0);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("unhalt_valid", {31'd0, out_valid}, 32'd1);
    chk("unhalt_pc", out_pc, 32'd0);
    chk("unhalt_instr", out_instr, 32'd100);

    // Redirect during a would-be handshake voids it, then back-to-back redirect.
    cyc(1, 1, 32'h40, 0);
    chk("redir_bubble", {31'd0, out_valid}, 32'd0);
    chk("redir_imem_pc", imem_pc, 32'h40);
    cyc(1, 1, 32'h50, 0);
    chk("redir2_bubble", {31'd0, out_valid}, 32'd0);
    chk("redir2_imem_pc", imem_pc, 32'h50);
    push(32'h50); push(32'h51);
    cyc(1, 0, 0, 0);
    chk("redir2_pc", out_pc, 32'h50);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);

    // Asynchronous reset in the middle of a stall.
    cyc(0, 0, 0, 0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_pc", out_pc, 32'h52);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_imem_pc", imem_pc, 32'd0);
    chk("async_rst_count", fetch_count, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
